// File: rtl/mlp_seq_pkg.sv
// Shared types and helpers for the sequential MLP classifier.
// Latency: n/a (package). Backpressure: n/a.
// Contents: FSM state enum, ReLU+saturate helper, packed-element extractor.
package mlp_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_L0,
    S_L1,
    S_DONE
  } state_e;

  // Parameter vectors are widened to this size before element extraction.
  localparam int FLAT_MAX_W = 1024;

  // Negative sums clamp to zero; non-negative sums are shifted, then clipped
  // to the largest value that fits in `width` bits.
  function automatic logic [31:0] relu_sat(input logic signed [63:0] acc,
                                           input int unsigned shift,
                                           input int unsigned width);
    logic signed [63:0] v;
    logic signed [63:0] vmax;
    vmax = (64'sd1 <<< width) - 64'sd1;
    if (acc < 0) return '0;
    v = acc >>> shift;
    if (v > vmax) v = vmax;
    return v[31:0];
  endfunction

  // Element `idx` of a flat packed vector of `width`-bit signed fields,
  // sign-extended to 32 bits.
  function automatic logic signed [31:0] get_elem(input logic [FLAT_MAX_W-1:0] flat,
                                                  input int idx,
                                                  input int width);
    logic [31:0]        raw;
    logic signed [31:0] t;
    raw = 32'(flat >> (idx * width));
    t   = raw << (32 - width);
    return t >>> (32 - width);
  endfunction

endpackage

// File: rtl/mlp_seq_argmax_mac.sv
// Signed multiply-accumulate register shared by both MLP layers.
// Latency: 1 cycle (acc updates on the edge after load/en). Backpressure: none.
// Ports: load_i (acc=bias_i, wins over en_i), en_i (acc+=a_i*w_i), acc_o
//        (accumulator including the current cycle's product when en_i is high).
module mlp_mac_unit #(
  parameter int A_W   = 9,
  parameter int W_W   = 8,
  parameter int ACC_W = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  logic                    en_i,
  input  logic [ACC_W-1:0]        bias_i,
  input  logic signed [A_W-1:0]   a_i,
  input  logic signed [W_W-1:0]   w_i,
  output logic signed [ACC_W-1:0] acc_o
);

  logic signed [ACC_W-1:0]     acc_q;
  logic signed [A_W+W_W-1:0]   prod;
  logic signed [ACC_W-1:0]     sum;

  assign prod  = a_i * w_i;
  // Sign-extend (or wrap) the product into the accumulator width.
  assign sum   = acc_q + ACC_W'(prod);
  // Exposing the post-MAC value lets the caller capture a neuron's final sum
  // on the same edge the accumulator is reloaded with the next bias.
  assign acc_o = en_i ? sum : acc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q <= '0;
    end else if (load_i) begin
      acc_q <= $signed(bias_i);
    end else if (en_i) begin
      acc_q <= sum;
    end
  end

endmodule

// File: rtl/mlp_seq_argmax.sv
// Time-multiplexed 2-layer quantised MLP with argmax, one shared signed MAC.
// Latency: accept at edge t -> out_valid seen high at edge t+N_HID*N_IN+N_OUT*N_HID+1.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
// Ports: in_valid/in_ready/in_data (features), out_valid/out_ready/out_class/
//        out_score (result), busy (not IDLE), clk, rst (sync, active-high).
module mlp_seq_argmax
  import mlp_seq_pkg::*;
#(
  parameter int N_IN      = 4,
  parameter int IN_W      = 4,
  parameter int N_HID     = 3,
  parameter int HID_W     = 8,
  parameter int N_OUT     = 3,
  parameter int W_W       = 8,
  parameter int ACC_W     = 20,
  parameter int HID_SHIFT = 0,
  parameter logic [N_HID*N_IN*W_W-1:0]  W0 = 96'h1040FFF8_0800FE00_E0E010F0,
  parameter logic [N_HID*ACC_W-1:0]     B0 = 60'hFFFE0_FFFF0_00010,
  parameter logic [N_OUT*N_HID*W_W-1:0] W1 = 72'h20F0E0_E0FCE0_C01020,
  parameter logic [N_OUT*ACC_W-1:0]     B1 = 60'hFFFC0_00040_FFFE0,
  localparam int CLS_W = $clog2(N_OUT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_IN*IN_W-1:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CLS_W-1:0]       out_class,
  output logic [ACC_W-1:0]       out_score,
  output logic                   busy
);

  localparam int IW  = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int HW  = (N_HID > 1) ? $clog2(N_HID) : 1;
  localparam int A_W = ((IN_W > HID_W) ? IN_W : HID_W) + 1;

  state_e                  state_q, state_d;
  logic [IW-1:0]           i_q;
  logic [HW-1:0]           j_q;
  logic [CLS_W-1:0]        k_q;
  logic [N_IN*IN_W-1:0]    x_q;
  logic [HID_W-1:0]        h_q [N_HID];
  logic [CLS_W-1:0]        best_cls_q;
  logic [ACC_W-1:0]        best_score_q;

  logic                    accept, i_last, j_last, k_last;
  logic                    mac_load, mac_en;
  logic [ACC_W-1:0]        bias_op;
  logic [A_W-1:0]          a_op;
  logic signed [W_W-1:0]   w_op;
  logic signed [ACC_W-1:0] acc;
  logic [ACC_W-1:0]        s_val;

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign out_class = best_cls_q;
  assign out_score = best_score_q;

  assign i_last = (i_q == IW'(N_IN - 1));
  assign j_last = (j_q == HW'(N_HID - 1));
  assign k_last = (k_q == CLS_W'(N_OUT - 1));
  assign s_val  = acc[ACC_W-1] ? '0 : acc;  // output-layer ReLU

  mlp_mac_unit #(.A_W(A_W), .W_W(W_W), .ACC_W(ACC_W)) u_mac (
    .clk    (clk),
    .rst    (rst),
    .load_i (mac_load),
    .en_i   (mac_en),
    .bias_i (bias_op),
    .a_i    ($signed(a_op)),
    .w_i    (w_op),
    .acc_o  (acc)
  );

  // Next state and MAC operand steering. Inputs and hidden activations are
  // unsigned, so they enter the MAC zero-extended with a 0 sign bit.
  always_comb begin
    state_d  = state_q;
    mac_load = 1'b0;
    mac_en   = 1'b0;
    bias_op  = ACC_W'(get_elem(FLAT_MAX_W'(B0), 0, ACC_W));
    a_op     = '0;
    w_op     = '0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d  = S_L0;
          mac_load = 1'b1;
        end
      end
      S_L0: begin
        mac_en = 1'b1;
        a_op   = A_W'(IN_W'(x_q >> (int'(i_q) * IN_W)));
        w_op   = W_W'(get_elem(FLAT_MAX_W'(W0), int'(j_q) * N_IN + int'(i_q), W_W));
        if (i_last) begin
          mac_load = 1'b1;
          if (j_last) begin
            state_d = S_L1;
            bias_op = ACC_W'(get_elem(FLAT_MAX_W'(B1), 0, ACC_W));
          end else begin
            bias_op = ACC_W'(get_elem(FLAT_MAX_W'(B0), int'(j_q) + 1, ACC_W));
          end
        end
      end
      S_L1: begin
        mac_en = 1'b1;
        a_op   = A_W'(h_q[j_q]);
        w_op   = W_W'(get_elem(FLAT_MAX_W'(W1), int'(k_q) * N_HID + int'(j_q), W_W));
        if (j_last) begin
          if (k_last) begin
            state_d = S_DONE;
          end else begin
            mac_load = 1'b1;
            bias_op  = ACC_W'(get_elem(FLAT_MAX_W'(B1), int'(k_q) + 1, ACC_W));
          end
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      i_q          <= '0;
      j_q          <= '0;
      k_q          <= '0;
      x_q          <= '0;
      best_cls_q   <= '0;
      best_score_q <= '0;
      for (int n = 0; n < N_HID; n++) h_q[n] <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          if (accept) x_q <= in_data;
        end
        S_L0: begin
          if (i_last) begin
            i_q      <= '0;
            h_q[j_q] <= HID_W'(relu_sat(64'(acc), HID_SHIFT, HID_W));
            j_q      <= j_last ? '0 : j_q + 1'b1;
          end else begin
            i_q <= i_q + 1'b1;
          end
        end
        S_L1: begin
          if (j_last) begin
            j_q <= '0;
            k_q <= k_last ? '0 : k_q + 1'b1;
            // Strict compare keeps the lower index on ties; class 0 seeds the best.
            if (k_q == '0 || s_val > best_score_q) begin
              best_score_q <= s_val;
              best_cls_q   <= k_q;
            end
          end else begin
            j_q <= j_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mlp_seq_argmax.sv
module tb_mlp_seq_argmax;

  localparam int PER = 10;

  logic        clk = 1'b0;
  always #(PER/2) clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [15:0] in_data;
  logic [1:0]  out_class;
  logic [19:0] out_score;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [15:0] b_in_data;
  logic [1:0]  b_out_class;
  logic [19:0] b_out_score;

  mlp_seq_argmax dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_class(out_class), .out_score(out_score), .busy(busy)
  );

  mlp_seq_argmax #(.W1('0), .B1('0)) dut_z (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_class(b_out_class), .out_score(b_out_score), .busy(b_busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
  endtask

  // Reference classifier from the default weights, plain integer arithmetic.
  function automatic void model(input logic [15:0] x, output int cls, output int score);
    int w0[3][4] = '{'{-16, 16, -32, -32}, '{0, -2, 0, 8}, '{-8, -1, 64, 16}};
    int b0[3]    = '{16, -16, -32};
    int w1[3][3] = '{'{32, 16, -64}, '{-32, -4, -32}, '{-32, -16, 32}};
    int b1[3]    = '{-32, 64, -64};
    int h[3];
    int a;
    for (int j = 0; j < 3; j++) begin
      a = b0[j];
      for (int i = 0; i < 4; i++) a += w0[j][i] * int'(x[i*4 +: 4]);
      h[j] = (a < 0) ? 0 : ((a > 255) ? 255 : a);
    end
    cls   = 0;
    score = -1;
    for (int k = 0; k < 3; k++) begin
      a = b1[k];
      for (int j = 0; j < 3; j++) a += w1[k][j] * h[j];
      if (a < 0) a = 0;
      if (a > score) begin
        score = a;
        cls   = k;
      end
    end
  endfunction

  // One full transaction on the default DUT with latency and handshake checks.
  task automatic run_vec(input logic [15:0] x, input int ecls, input int escore, input string tag);
    int n;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, " in_ready before accept"}, in_ready, 1);
    in_data  = x;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    check({tag, " latency"}, n, 22);
    check({tag, " class"}, out_class, ecls);
    check({tag, " score"}, out_score, escore);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, " out_valid after handshake"}, out_valid, 0);
    check({tag, " in_ready after handshake"}, in_ready, 1);
  endtask

  typedef struct {
    logic [15:0] x;
    int          cls;
    int          score;
  } vec_t;

  typedef struct {
    int cls;
    int score;
    int cyc;
  } exp_t;

  initial begin
    #(PER * 20000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[3];
    exp_t        q[$];
    exp_t        e;
    int          ecls, escore, n, cnt, cycle, last_acc, nres;
    logic [15:0] x;

    tbl[0] = '{16'h0000, 0, 480};
    tbl[1] = '{16'h0F00, 2, 8096};
    tbl[2] = '{16'h000F, 1, 64};

    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    b_in_valid = 1'b0; b_out_ready = 1'b0; b_in_data = '0;
    repeat (3) @(negedge clk);
    check("reset out_valid", out_valid, 0);
    check("reset out_class", out_class, 0);
    check("reset out_score", out_score, 0);
    check("reset busy", busy, 0);
    check("in_ready low during rst", in_ready, 0);
    rst = 1'b0;
    #1;
    check("in_ready after rst", in_ready, 1);

    // Directed vectors
    for (int t = 0; t < 3; t++) run_vec(tbl[t].x, tbl[t].cls, tbl[t].score, $sformatf("vec%0d", t));

    // Zero output layer: all scores tie at 0, class 0 wins
    @(negedge clk);
    b_in_data = 16'($urandom);
    b_in_valid = 1'b1;
    b_out_ready = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0;
    n = 1;
    while (!b_out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("zeroW1 latency", n, 22);
    check("zeroW1 class", b_out_class, 0);
    check("zeroW1 score", b_out_score, 0);

    // Random vectors against the model
    for (int t = 0; t < 8; t++) begin
      x = 16'($urandom);
      model(x, ecls, escore);
      run_vec(x, ecls, escore, $sformatf("rand%0d", t));
    end

    // Output held under backpressure, in_valid ignored
    x = 16'($urandom);
    model(x, ecls, escore);
    @(negedge clk);
    in_data = x;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("hold first class", out_class, ecls);
    for (int c = 0; c < 10; c++) begin
      in_valid = c[0];
      in_data  = 16'($urandom);
      @(negedge clk);
      check($sformatf("hold%0d out_valid", c), out_valid, 1);
      check($sformatf("hold%0d class", c), out_class, ecls);
      check($sformatf("hold%0d score", c), out_score, escore);
      check($sformatf("hold%0d in_ready", c), in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("hold release out_valid", out_valid, 0);
    check("hold release in_ready", in_ready, 1);
    check("hold release busy", busy, 0);

    // Reset mid-L1 aborts the vector
    @(negedge clk);
    in_data = 16'h0F00;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (15) @(negedge clk);
    check("abort busy before rst", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort in_ready after rst", in_ready, 1);
    check("abort busy after rst", busy, 0);
    cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (out_valid) cnt++;
    end
    check("abort no out_valid", cnt, 0);
    x = 16'($urandom);
    model(x, ecls, escore);
    run_vec(x, ecls, escore, "post-abort");

    // Back-to-back with constant valid/ready
    @(negedge clk);
    in_valid = 1'b1;
    out_ready = 1'b1;
    in_data = 16'($urandom);
    cycle = 0;
    last_acc = -1;
    nres = 0;
    while (nres < 5 && cycle < 400) begin
      if (out_valid) begin
        if (q.size() == 0) begin
          check("b2b unexpected result", 1, 0);
        end else begin
          e = q.pop_front();
          check($sformatf("b2b%0d class", nres), out_class, e.cls);
          check($sformatf("b2b%0d score", nres), out_score, e.score);
          check($sformatf("b2b%0d latency", nres), cycle - e.cyc, 22);
        end
        nres++;
      end
      if (in_ready) begin
        model(in_data, e.cls, e.score);
        e.cyc = cycle;
        q.push_back(e);
        if (last_acc >= 0) check("b2b period", cycle - last_acc, 23);
        last_acc = cycle;
      end else begin
        in_data = 16'($urandom);
      end
      @(negedge clk);
      cycle++;
    end
    check("b2b result count", nres, 5);
    in_valid = 1'b0;
    out_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mlp_seq_argmax.md
Name: mlp_seq_argmax

Overview:
Time-multiplexed, parametrised two-layer quantised MLP classifier with argmax output. It replaces the fully-parallel combinational classifier with one shared signed MAC stepped by an FSM, and weights and biases are set by parameters. It sits between the sensor/feature front-end (valid/ready in) and the decision consumer (valid/ready out), and returns the winning class index plus its score.

Parameters:
N_IN, 4, number of input features
IN_W, 4, unsigned input feature width
N_HID, 3, hidden neurons
HID_W, 8, unsigned hidden activation width (post-saturation)
N_OUT, 3, output classes (>=2)
W_W, 8, signed weight width
ACC_W, 20, signed accumulator width; also the width of out_score
HID_SHIFT, 0, arithmetic right shift applied to layer-0 sums before saturation
W0, Iris set {{-16,16,-32,-32},{0,-2,0,8},{-8,-1,64,16}}, layer-0 weights; element [j][i] is packed flat at bit (j*N_IN+i)*W_W, W_W bits each
B0, {16,-16,-32}, layer-0 biases; ACC_W bits each, in accumulator units
W1, {{32,16,-64},{-32,-4,-32},{-32,-16,32}}, layer-1 weights; element [k][j] is packed flat at bit (k*N_HID+j)*W_W
B1, {-32,64,-64}, layer-1 biases; ACC_W bits each
CLS_W, derived, $clog2(N_OUT); local, not overridable

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  input vector valid
in_ready  out  1  block can accept an input vector
in_data  in  N_IN*IN_W  feature i at bits [i*IN_W +: IN_W], unsigned
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_class  out  CLS_W  argmax index
out_score  out  ACC_W  winning post-ReLU score, unsigned value held in ACC_W bits
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset: one clk edge with rst=1 forces state IDLE. Reset values: out_valid=0, out_class=0, out_score=0, busy=0, counters=0, hidden regs=0. in_ready=(state==IDLE)&&!rst.
- Reset asserted mid-operation aborts the computation. No partial result is ever emitted.
- FSM states: IDLE -> L0 -> L1 -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch in_data, load acc=B0[0], enter L0.
- L0: one MAC per cycle, acc += W0[j][i]*x[i]. Inputs are zero-extended to signed.
  - At i=N_IN-1, write hidden reg h[j]:
    - If final sum<0, h[j]=0.
    - Otherwise v = sum>>>HID_SHIFT, and h[j] = min(v, 2^HID_W-1).
  - Then reload acc=B0[j+1], or B1[0] when moving to L1.
  - Takes N_HID*N_IN cycles.
- L1: acc += W1[k][j]*h[j], one MAC per cycle.
  - At j=N_HID-1, s[k] = max(sum,0).
  - Running argmax: replace the best only if s[k] > best (strict), so ties keep the lower index. k=0 always loads the best.
  - Takes N_OUT*N_HID cycles.
- DONE:
  - out_valid=1, and out_class/out_score are registered and stable.
  - Held until out_ready=1; then go to IDLE and clear out_valid next cycle.
  - in_valid is ignored outside IDLE.
- Latency:
  - Accept at edge t gives out_valid high at t+N_HID*N_IN+N_OUT*N_HID+1 (22 with defaults).
  - With out_ready=1 constantly, the next accept happens 1 cycle after the output handshake, so the period is 23 cycles with defaults.
- Arithmetic:
  - Products are (IN_W+1)xW_W or (HID_W+1)xW_W signed, sign-extended to ACC_W.
  - acc wraps in two's complement; no overflow detection. Choosing ACC_W large enough is the integrator's responsibility.
- Counters: i, j and k wrap to 0 at their bound. No off-by-one: exactly N_IN (or N_HID) MAC cycles per neuron.

Decomposition:
- Package mlp_seq_pkg:
  - FSM state enum.
  - Function relu_sat(acc, shift, width).
  - Function to extract a packed weight/bias element.
- Sub-module mlp_mac_unit:
  - Signed multiply-accumulate register, ACC_W wide.
  - Inputs: load (acc=bias), en (acc+=a*w).
  - Output: acc.
  - FSM, counters, hidden regs and argmax stay in the top.

Test Plan:
- Defaults, in_data features {0,0,0,0}: h={16,0,0}, s={480,0,0}; out_class=0, out_score=480, out_valid exactly 22 cycles after accept.
- Defaults, x2=15, other features 0: h2 saturates at 255, h={0,0,255}, s={0,0,8096}; out_class=2, out_score=8096.
- Defaults, x0=15, other features 0: h={0,0,0}, s={0,64,0}; out_class=1, out_score=64.
- Override W1=0 and B1=0: all scores 0, tie resolves to out_class=0, out_score=0.
- Hold out_ready=0 for 10 cycles after out_valid:
  - out_valid, out_class and out_score stay stable.
  - in_ready stays 0.
  - in_valid pulses are ignored.
  - Release out_ready: out_valid falls next cycle, in_ready rises.
- Assert rst for 1 cycle mid-L1, then run a fresh vector:
  - out_valid never pulses for the aborted vector.
  - in_ready=1 the cycle after rst drops.
  - The fresh vector gives the correct result.
- Back-to-back: in_valid=1 and out_ready=1 constantly gives one result every 23 cycles, all matching the golden model.
